// File: rtl/uart_mem_cmd_initiator.sv
// Host-side initiator for the UART memory-access protocol: serializes one read/write
// request into a command frame on a byte TX interface and collects the response bytes.
module uart_mem_cmd_initiator #(
    parameter int         MEM_SELECT_BITS = 4,
    parameter int         TIMEOUT_CYCLES  = 120000,
    parameter logic [7:0] ACK_BYTE        = 8'hAA
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [MEM_SELECT_BITS-1:0] req_block,
    input  logic [7:0]                 req_addr,
    input  logic [15:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [15:0]                rsp_rdata,
    output logic                       rsp_error,
    output logic                       uart_tx_en,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_tx_busy,
    input  logic                       uart_rx_valid,
    input  logic [7:0]                 uart_rx_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Handshake: a request is taken on a clk edge where req_valid && req_ready; req_ready is
    // a registered IDLE flag, rsp_valid is a single-cycle pulse, uart_tx_en a single-cycle strobe.
    typedef enum logic [2:0] {IDLE, SEND, TX_WAIT, RESP, DONE} state_t;

    state_t                     state, state_d;
    logic                       wr_q, wr_d;
    logic [MEM_SELECT_BITS-1:0] block_q, block_d;
    logic [7:0]                 addr_q, addr_d;
    logic [15:0]                wdata_q, wdata_d;
    logic [2:0]                 idx_q, idx_d;
    logic                       first_q, first_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       got_hi_q, got_hi_d;
    logic [7:0]                 rd_hi_q, rd_hi_d;
    logic                       req_ready_d, rsp_valid_d, rsp_error_d, tx_en_d;
    logic [15:0]                rsp_rdata_d;
    logic [7:0]                 tx_data_d;
    logic [7:0]                 frame_byte;
    logic [2:0]                 last_idx;

    assign last_idx = wr_q ? 3'd4 : 3'd2;

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = wr_q ? 8'h01 : 8'h02;
            3'd1:    frame_byte = 8'(block_q);
            3'd2:    frame_byte = addr_q;
            3'd3:    frame_byte = wdata_q[15:8];
            default: frame_byte = wdata_q[7:0];
        endcase
    end

    always_comb begin
        state_d     = state;
        wr_d        = wr_q;
        block_d     = block_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        first_d     = first_q;
        timer_d     = timer_q;
        got_hi_d    = got_hi_q;
        rd_hi_d     = rd_hi_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_error_d = rsp_error;
        tx_en_d     = 1'b0;
        tx_data_d   = uart_tx_data;
        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    wr_d        = req_write;
                    block_d     = req_block;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    idx_d       = 3'd0;
                    got_hi_d    = 1'b0;
                    rd_hi_d     = 8'h00;
                    req_ready_d = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (!uart_tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = frame_byte;
                    first_d   = 1'b1;
                    state_d   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The transmitter raises busy one cycle after the strobe, so skip that cycle.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!uart_tx_busy) begin
                    if (idx_q == last_idx) begin
                        timer_d = '0;
                        state_d = RESP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            RESP: begin
                if (uart_rx_valid) begin
                    timer_d = '0;
                    if (wr_q) begin
                        rsp_rdata_d = 16'h0000;
                        rsp_error_d = (uart_rx_data != ACK_BYTE);
                        rsp_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (!got_hi_q) begin
                        rd_hi_d  = uart_rx_data;
                        got_hi_d = 1'b1;
                    end else begin
                        rsp_rdata_d = {rd_hi_q, uart_rx_data};
                        rsp_error_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Missing bytes report as zero; rd_hi_q was cleared on accept.
                    rsp_rdata_d = {rd_hi_q, 8'h00};
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            block_q      <= '0;
            addr_q       <= 8'h00;
            wdata_q      <= 16'h0000;
            idx_q        <= 3'd0;
            first_q      <= 1'b0;
            timer_q      <= '0;
            got_hi_q     <= 1'b0;
            rd_hi_q      <= 8'h00;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            rsp_error    <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            state        <= state_d;
            wr_q         <= wr_d;
            block_q      <= block_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            first_q      <= first_d;
            timer_q      <= timer_d;
            got_hi_q     <= got_hi_d;
            rd_hi_q      <= rd_hi_d;
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_error    <= rsp_error_d;
            uart_tx_en   <= tx_en_d;
            uart_tx_data <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_mem_cmd_initiator.sv
// Bench for uart_mem_cmd_initiator: directed requests, a busy-driven transmitter model,
// hand-written expected frames/responses in queues, and a monitor that pops and compares.
module tb_uart_mem_cmd_initiator;

    localparam int MSB       = 4;
    localparam int TO        = 300;
    localparam int BYTE_TIME = 12;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_block = 4'h0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int rsp_seen = 0;
    int busy_cnt = 0;
    logic hold_busy = 1'b0;
    logic prev_tx_en = 1'b0;
    logic prev_rsp_valid = 1'b0;

    logic [7:0]  exp_q[$];
    logic [17:0] exp_rsp_q[$];

    uart_mem_cmd_initiator #(
        .MEM_SELECT_BITS(MSB),
        .TIMEOUT_CYCLES (TO),
        .ACK_BYTE       (8'hAA)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_block    (req_block),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // transmitter model: busy rises the cycle after a strobe and lasts BYTE_TIME cycles
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) busy_cnt--;
            if (uart_tx_en) busy_cnt = BYTE_TIME;
            uart_tx_busy = hold_busy || (busy_cnt != 0);
        end
    end

    // monitor
    initial begin
        logic [7:0]  e;
        logic [17:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (uart_tx_en) begin
                tx_seen++;
                checks++;
                if (uart_tx_busy) begin
                    errors++;
                    $display("FAIL tx_while_busy: tx_en=1 busy=%0b required busy=0", uart_tx_busy);
                end
                checks++;
                if (prev_tx_en) begin
                    errors++;
                    $display("FAIL tx_pulse_width: tx_en high 2 cycles, required 1");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: byte %h, required no byte", uart_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (uart_tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h required %h", uart_tx_data, e);
                    end
                end
            end
            if (rsp_valid) begin
                rsp_seen++;
                checks++;
                if (prev_rsp_valid) begin
                    errors++;
                    $display("FAIL rsp_pulse_width: rsp_valid high 2 cycles, required 1");
                end
                checks++;
                if (exp_rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: err=%0b rdata=%h, required no response",
                             rsp_error, rsp_rdata);
                end else begin
                    r = exp_rsp_q.pop_front();
                    if (rsp_error !== r[16] || (r[17] && rsp_rdata !== r[15:0])) begin
                        errors++;
                        $display("FAIL rsp: got err=%0b rdata=%h required err=%0b rdata=%h",
                                 rsp_error, rsp_rdata, r[16], r[15:0]);
                    end
                end
            end
            prev_tx_en     = uart_tx_en;
            prev_rsp_valid = rsp_valid;
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_tx(input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(bytes[39-8*i -: 8]);
    endtask

    task automatic expect_rsp(input logic chk_rd, input logic err, input logic [15:0] rd);
        exp_rsp_q.push_back({chk_rd, err, rd});
    endtask

    task automatic issue(input logic wr, input logic [3:0] blk, input logic [7:0] addr,
                         input logic [15:0] wd);
        int n = 0;
        while (!req_ready && n < 1000) begin
            tick();
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_block = blk;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(1, 0));
        req_block = 4'($urandom_range(15, 0));
        req_addr  = 8'($urandom_range(255, 0));
        req_wdata = 16'($urandom_range(65535, 0));
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while ((exp_q.size() != 0 || uart_tx_busy) && n < 5000) begin
            tick();
            n++;
        end
        chk("tx_frame_done", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    task automatic send_rx(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        tick();
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'($urandom_range(255, 0));
        tick();
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (exp_rsp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("rsp_arrived", exp_rsp_q.size(), 32'd0);
        exp_rsp_q.delete();
        tick();
    endtask

    // stimulus
    initial begin
        int saved;
        int n;
        repeat (3) tick();
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("reset_tx_en", {31'd0, uart_tx_en}, 32'd0);
        chk("reset_tx_data", {24'd0, uart_tx_data}, 32'd0);
        resetn = 1'b1;
        chk("release_req_ready_low", {31'd0, req_ready}, 32'd0);
        tick();
        chk("release_req_ready_high", {31'd0, req_ready}, 32'd1);

        // write BEEF, acked
        expect_tx(40'h01_03_10_BE_EF, 5);
        expect_rsp(1'b0, 1'b0, 16'h0000);
        issue(1'b1, 4'd3, 8'h10, 16'hBEEF);
        chk("req_ready_drops", {31'd0, req_ready}, 32'd0);
        wait_tx_done();
        send_rx(8'hAA);
        wait_rsp(200);

        // read 0x1234
        expect_tx(40'h02_00_FF_00_00, 3);
        expect_rsp(1'b1, 1'b0, 16'h1234);
        issue(1'b0, 4'd0, 8'hFF, 16'h0000);
        wait_tx_done();
        send_rx(8'h12);
        send_rx(8'h34);
        wait_rsp(200);

        // transmitter held busy mid-frame
        expect_tx(40'h01_05_3C_13_57, 5);
        expect_rsp(1'b0, 1'b0, 16'h0000);
        issue(1'b1, 4'd5, 8'h3C, 16'h1357);
        n = 0;
        while (exp_q.size() > 3 && n < 2000) begin
            tick();
            n++;
        end
        chk("hold_two_bytes_sent", exp_q.size(), 32'd3);
        hold_busy = 1'b1;
        saved = tx_seen;
        repeat (500) tick();
        chk("hold_no_tx", tx_seen, saved);
        hold_busy = 1'b0;
        wait_tx_done();
        send_rx(8'hAA);
        wait_rsp(200);

        // read with one byte only: timeout
        expect_tx(40'h02_09_42_00_00, 3);
        expect_rsp(1'b1, 1'b1, 16'hAB00);
        issue(1'b0, 4'd9, 8'h42, 16'h0000);
        wait_tx_done();
        send_rx(8'hAB);
        wait_rsp(TO + 200);

        // write answered with a bad ack
        expect_tx(40'h01_0F_7E_01_02, 5);
        expect_rsp(1'b0, 1'b1, 16'h0000);
        issue(1'b1, 4'hF, 8'h7E, 16'h0102);
        wait_tx_done();
        send_rx(8'h55);
        wait_rsp(200);

        // spurious bytes in IDLE
        saved = rsp_seen;
        send_rx(8'hAA);
        send_rx(8'h12);
        repeat (20) tick();
        chk("idle_spurious_rsp", rsp_seen, saved);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // reset during the third byte
        expect_tx(40'h01_02_20_CA_FE, 5);
        saved = tx_seen;
        issue(1'b1, 4'd2, 8'h20, 16'hCAFE);
        n = 0;
        while (tx_seen < saved + 3 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("reset_third_byte_seen", tx_seen, saved + 3);
        resetn = 1'b0;
        #1;
        chk("midreset_tx_en", {31'd0, uart_tx_en}, 32'd0);
        chk("midreset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midreset_tx_data", {24'd0, uart_tx_data}, 32'd0);
        exp_q.delete();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        // read after reset
        expect_tx(40'h02_07_80_00_00, 3);
        expect_rsp(1'b1, 1'b0, 16'h5AA5);
        issue(1'b0, 4'd7, 8'h80, 16'h0000);
        wait_tx_done();
        send_rx(8'h5A);
        send_rx(8'hA5);
        wait_rsp(200);

        repeat (5) tick();
        chk("final_tx_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mem_cmd_initiator.md
Name: uart_mem_cmd_initiator

Overview:
Host-side initiator for the UART memory-access command protocol served by the FPGA memory controller. It accepts one parallel read or write request at a time and serializes it into a command byte frame on a uart_tx-style byte interface. It then collects the response bytes from a uart_rx-style byte interface and returns read data or a completion status. It is used as the bench and board-to-board driver for the controller, sitting between user logic and a uart_tx/uart_rx pair.

Parameters:
MEM_SELECT_BITS, 4, width of block-select field (log2 of EBR count)
TIMEOUT_CYCLES, 120000, clk cycles allowed from last command byte sent to each response byte
ACK_BYTE, 8'hAA, response byte that confirms a write

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  initiator idle, accepts request
req_write  input  1  1 = write, 0 = read
req_block  input  MEM_SELECT_BITS  target EBR select
req_addr  input  8  word address within block
req_wdata  input  16  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  16  read data (valid with rsp_valid, read only)
rsp_error  output  1  with rsp_valid: timeout or bad ack
uart_tx_en  output  1  one-cycle byte send strobe
uart_tx_data  output  8  byte to send
uart_tx_busy  input  1  transmitter busy
uart_rx_valid  input  1  received byte strobe
uart_rx_data  input  8  received byte

Behaviour:
- Reset (async, resetn low) values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, uart_tx_en=0, uart_tx_data=0. Internal state=IDLE, timer=0, byte index=0. req_ready goes to 1 on the first clk edge after reset release.
- Frame format:
  - Write: 8'h01, {pad0, req_block}, req_addr, wdata[15:8], wdata[7:0].
  - Read: 8'h02, {pad0, req_block}, req_addr.
  - Block byte is zero-extended to 8 bits; MEM_SELECT_BITS must be ≤ 8.
- Responses: write expects one byte equal to ACK_BYTE. Read expects two bytes, high then low.
- States: IDLE, SEND, TX_WAIT, RESP, DONE.
- IDLE: req_ready=1. When req_valid&&req_ready, capture all req_* fields into registers, clear the byte index, go to SEND. req_ready drops in the following cycle.
- SEND: when uart_tx_busy=0, drive uart_tx_data=frame[index] and pulse uart_tx_en for exactly one cycle, then go to TX_WAIT.
- TX_WAIT: ignore busy for the first cycle (transmitter latency), then wait for busy=0.
  - If more bytes remain: index+1, back to SEND.
  - After the last byte: clear timer, go to RESP.
- RESP: timer increments each cycle and resets to 0 on every uart_rx_valid.
  - Write: first byte received → go to DONE; error=1 if byte≠ACK_BYTE.
  - Read: first byte → rdata[15:8]; second byte → rdata[7:0]; then go to DONE with error=0.
  - If timer reaches TIMEOUT_CYCLES-1 without a byte: go to DONE with error=1. rsp_rdata holds whatever bytes were captured; missing bytes are 0.
- DONE: rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_error stable, then return to IDLE. rsp_rdata and rsp_error hold until the next rsp_valid.
- uart_rx_valid outside RESP is ignored and never corrupts state. Bytes arriving after the expected count within RESP are not possible, since the state leaves RESP on the last expected byte.
- req_valid outside IDLE is ignored; request fields may change freely once accepted.
- Latency, write frame with idle transmitter: 5 byte times + response time + 1 cycle to rsp_valid.
- Reset mid-frame: outputs return to their reset values immediately. A partially sent frame is abandoned; the controller side recovers via its own reset.

Test Plan:
- Write: req block=3, addr=8'h10, wdata=16'hBEEF. → tx bytes 01,03,10,BE,EF, each with a single tx_en pulse. Respond AA → rsp_valid for 1 cycle, error=0.
- Read: block=0, addr=8'hFF. → tx bytes 02,00,FF. Respond 12 then 34 → rsp_rdata=16'h1234, error=0.
- Hold uart_tx_busy=1 for 500 cycles mid-frame → no tx_en pulse while busy, byte order intact.
- Read with only 1 response byte (8'hAB) → after TIMEOUT_CYCLES, rsp_valid with error=1 and rsp_rdata=16'hAB00.
- Write answered with 8'h55 → error=1. Spurious rx bytes in IDLE → no rsp_valid.
- Assert resetn low during the third tx byte → tx_en=0 and req_ready=0 immediately. After release, a new read completes correctly.
